// File: rtl/bp_common_pkg.sv
// Shared types for the cache request arbiter: FSM state encoding and requester indices.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_wait_md = 2'd1,
    e_busy    = 2'd2
  } bp_cache_req_arb_state_e;

  localparam int unsigned num_cache_req_lp = 2;
  localparam logic        icache_idx_lp    = 1'b0;
  localparam logic        dcache_idx_lp    = 1'b1;

endpackage

// File: rtl/bp_cache_req_rr_arb.sv
// Two-input round-robin grant: a lone valid requester wins, otherwise the pointer decides.
module bp_cache_req_rr_arb
  import bp_common_pkg::*;
(
  input  logic [1:0] v_i,
  input  logic       rr_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = rr_i;
    case (v_i)
      2'b01:   grant_o = icache_idx_lp;
      2'b10:   grant_o = dcache_idx_lp;
      default: grant_o = rr_i;
    endcase
  end

endmodule

// File: rtl/bp_cache_req_arbiter.sv
// Arbitrates I$ and D$ cache requests onto one LCE port; one request outstanding at a time,
// metadata and completion are steered by the registered owner.
module bp_cache_req_arbiter
  import bp_common_pkg::*;
#(
  parameter int unsigned req_width_p      = 128,
  parameter int unsigned metadata_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [1:0][req_width_p-1:0]      cache_req_i,
  input  logic [1:0]                       cache_req_v_i,
  output logic [1:0]                       cache_req_ready_o,
  input  logic [1:0][metadata_width_p-1:0] cache_req_metadata_i,
  input  logic [1:0]                       cache_req_metadata_v_i,
  output logic [1:0]                       cache_req_complete_o,

  output logic [req_width_p-1:0]           cache_req_o,
  output logic                             cache_req_v_o,
  input  logic                             cache_req_ready_i,
  output logic [metadata_width_p-1:0]      cache_req_metadata_o,
  output logic                             cache_req_metadata_v_o,
  input  logic                             cache_req_complete_i,

  output logic                             owner_o,
  output logic                             busy_o
);

  bp_cache_req_arb_state_e state_q, state_n;
  logic owner_q, owner_n;
  logic rr_q, rr_n;
  logic grant;
  logic any_v;
  logic in_idle, in_wait_md, in_flight;
  logic handshake;

  bp_cache_req_rr_arb u_rr_arb (
    .v_i     (cache_req_v_i),
    .rr_i    (rr_q),
    .grant_o (grant)
  );

  // Qualify every state decode with reset so outputs drop while reset is held.
  assign any_v      = |cache_req_v_i;
  assign in_idle    = (state_q == e_idle) & ~reset_i;
  assign in_wait_md = (state_q == e_wait_md) & ~reset_i;
  assign in_flight  = (state_q != e_idle) & ~reset_i;
  assign handshake  = cache_req_v_o & cache_req_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      rr_q    <= rr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    rr_n    = rr_q;
    case (state_q)
      e_idle: begin
        if (handshake) begin
          state_n = e_wait_md;
          owner_n = grant;
          rr_n    = ~grant;
        end
      end
      e_wait_md: begin
        // Completion wins over metadata arriving in the same cycle.
        if (cache_req_complete_i)
          state_n = e_idle;
        else if (cache_req_metadata_v_i[owner_q])
          state_n = e_busy;
      end
      e_busy: begin
        if (cache_req_complete_i)
          state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    cache_req_v_o          = in_idle & any_v;
    cache_req_o            = cache_req_i[grant];
    cache_req_ready_o      = 2'b00;
    cache_req_ready_o[grant] = in_idle & any_v & cache_req_ready_i;
    cache_req_metadata_o   = cache_req_metadata_i[owner_q];
    cache_req_metadata_v_o = in_wait_md & cache_req_metadata_v_i[owner_q];
    cache_req_complete_o   = 2'b00;
    cache_req_complete_o[owner_q] = in_flight & cache_req_complete_i;
  end

  assign busy_o  = (state_q != e_idle);
  assign owner_o = owner_q;

endmodule
